// File: rtl/morse_key_classifier.sv
// Morse key front end: synchronizes and debounces the raw key, times each press
// as dot/dash, and packs up to MAX_SYMBOLS symbols into a letter word.
module morse_key_classifier #(
  parameter int DEBOUNCE_CYCLES = 280000,
  parameter int DASH_CYCLES     = 5600000,
  parameter int GAP_CYCLES      = 14000000,
  parameter int MAX_SYMBOLS     = 4
) (
  input  logic       CLKin,
  input  logic       RSTn,
  input  logic       key_n,
  output logic       pressed,
  output logic       sym_valid,
  output logic       sym_bit,
  output logic [2:0] sym_count,
  output logic [3:0] symbols,
  output logic       letter_end
);

  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = $clog2(DASH_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DASH_MAX = DW'(DASH_CYCLES);
  localparam logic [DW-1:0] DASH_THR = DW'(DASH_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]    MAX_CNT  = 3'(MAX_SYMBOLS);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  logic [1:0]    sync_q;
  logic          key_lvl;
  logic [BW-1:0] deb_cnt;
  state_t        state;
  logic [DW-1:0] dur;
  logic [GW-1:0] gap_cnt;
  logic          fresh;

  logic [2:0]    idx;
  logic [2:0]    cnt_next;
  logic [3:0]    sym_next;
  logic          full;

  assign key_lvl = ~sync_q[1];

  always_ff @(posedge CLKin or negedge RSTn) begin
    if (!RSTn) begin
      sync_q  <= 2'b11;
      deb_cnt <= '0;
      pressed <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      if (key_lvl != pressed) begin
        if (deb_cnt == DEB_LAST) begin
          pressed <= key_lvl;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // A fresh letter starts from an empty word; otherwise append at sym_count.
  always_comb begin
    idx      = fresh ? 3'd0 : sym_count;
    sym_next = fresh ? 4'd0 : symbols;
    sym_next[idx[1:0]] = sym_bit;
    cnt_next = idx + 3'd1;
    full     = (cnt_next == MAX_CNT);
  end

  always_ff @(posedge CLKin or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      dur        <= '0;
      gap_cnt    <= '0;
      fresh      <= 1'b1;
      sym_valid  <= 1'b0;
      sym_bit    <= 1'b0;
      sym_count  <= '0;
      symbols    <= '0;
      letter_end <= 1'b0;
    end else begin
      sym_valid  <= 1'b0;
      letter_end <= 1'b0;

      if (sym_valid) begin
        symbols   <= sym_next;
        sym_count <= cnt_next;
        fresh     <= full;
        if (full) letter_end <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pressed) begin
            state <= PRESS;
            dur   <= '0;
          end
        end
        PRESS: begin
          // dur trails the pressed level by the edge cycle spent in IDLE
          if (!pressed) begin
            sym_valid <= 1'b1;
            sym_bit   <= (dur >= DASH_THR);
            state     <= GAP;
            gap_cnt   <= '0;
          end else if (dur != DASH_MAX) begin
            dur <= dur + 1'b1;
          end
        end
        GAP: begin
          if (sym_valid && full) begin
            state <= IDLE;
          end else if (gap_cnt == GAP_LAST) begin
            if (!fresh) letter_end <= 1'b1;
            fresh   <= 1'b1;
            gap_cnt <= '0;
            dur     <= '0;
            state   <= pressed ? PRESS : IDLE;
          end else if (pressed) begin
            state   <= PRESS;
            dur     <= '0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_key_classifier.sv
// Directed bench for morse_key_classifier with short debounce/dash/gap timings.
module tb_morse_key_classifier;

  logic       clk;
  logic       rst_n;
  logic       key_n;
  logic       pressed;
  logic       sym_valid;
  logic       sym_bit;
  logic [2:0] sym_count;
  logic [3:0] symbols;
  logic       letter_end;

  int n_cmp = 0;
  int n_err = 0;

  int         cyc = 0;
  int         sv_cnt, le_cnt, pr_rise;
  int         sv_cyc, le_cyc, rel_cyc;
  bit         sv_q[$];
  logic [2:0] post_cnt, le_cnt_val;
  logic [3:0] post_sym, le_sym;
  logic       sv_prev = 1'b0;
  logic       pr_prev = 1'b0;

  morse_key_classifier #(
    .DEBOUNCE_CYCLES(4),
    .DASH_CYCLES    (20),
    .GAP_CYCLES     (50),
    .MAX_SYMBOLS    (4)
  ) dut (
    .CLKin     (clk),
    .RSTn      (rst_n),
    .key_n     (key_n),
    .pressed   (pressed),
    .sym_valid (sym_valid),
    .sym_bit   (sym_bit),
    .sym_count (sym_count),
    .symbols   (symbols),
    .letter_end(letter_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (sv_prev === 1'b1) begin
      post_cnt = sym_count;
      post_sym = symbols;
    end
    if (sym_valid === 1'b1) begin
      sv_cnt++;
      sv_cyc = cyc;
      sv_q.push_back(sym_bit);
    end
    if (letter_end === 1'b1) begin
      le_cnt++;
      le_cyc     = cyc;
      le_cnt_val = sym_count;
      le_sym     = symbols;
    end
    if (pressed === 1'b1 && pr_prev !== 1'b1) pr_rise++;
    pr_prev = pressed;
    sv_prev = sym_valid;
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    sv_cnt = 0; le_cnt = 0; pr_rise = 0;
    sv_cyc = -1; le_cyc = -1;
    post_cnt = 'x; post_sym = 'x; le_cnt_val = 'x; le_sym = 'x;
    sv_q.delete();
  endtask

  task automatic do_reset();
    key_n = 1'b1;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic press(input int n);
    key_n = 1'b0;
    tick(n);
    key_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    key_n = 1'b1;
    rst_n = 1'b0;
    tick(2);
    outs = {pressed, sym_valid, sym_bit, sym_count, symbols, letter_end};
    n_cmp++; if (outs !== 11'd0) begin n_err++; $display("FAIL reset_outputs: got %b expected 0", outs); end
    rst_n = 1'b1;
    clear_mon();
    tick(100);
    n_cmp++; if (sv_cnt !== 0) begin n_err++; $display("FAIL reset_idle_sym_valid: got %0d expected 0", sv_cnt); end
    n_cmp++; if (le_cnt !== 0) begin n_err++; $display("FAIL reset_idle_letter_end: got %0d expected 0", le_cnt); end
    n_cmp++; if (pr_rise !== 0) begin n_err++; $display("FAIL reset_idle_pressed: got %0d expected 0", pr_rise); end
  endtask

  task automatic test_single_dot();
    do_reset();
    press(10);
    tick(70);
    n_cmp++; if (sv_cnt !== 1) begin n_err++; $display("FAIL dot_sym_valid_count: got %0d expected 1", sv_cnt); end
    n_cmp++; if (sv_q.size() < 1 || sv_q[0] !== 1'b0) begin n_err++; $display("FAIL dot_sym_bit: got %0d expected 0", sv_q.size() > 0 ? int'(sv_q[0]) : -1); end
    n_cmp++; if (sv_cyc - rel_cyc !== 7) begin n_err++; $display("FAIL dot_latency: got %0d expected 7", sv_cyc - rel_cyc); end
    n_cmp++; if (post_cnt !== 3'd1) begin n_err++; $display("FAIL dot_post_count: got %0d expected 1", post_cnt); end
    n_cmp++; if (post_sym !== 4'b0000) begin n_err++; $display("FAIL dot_post_symbols: got %b expected 0000", post_sym); end
    n_cmp++; if (le_cnt !== 1) begin n_err++; $display("FAIL dot_letter_end_count: got %0d expected 1", le_cnt); end
    n_cmp++; if (le_cyc - sv_cyc !== 50) begin n_err++; $display("FAIL dot_gap_timing: got %0d expected 50", le_cyc - sv_cyc); end
    n_cmp++; if (le_cnt_val !== 3'd1) begin n_err++; $display("FAIL dot_letter_count: got %0d expected 1", le_cnt_val); end
  endtask

  task automatic test_full_letter();
    logic [3:0] bits;
    do_reset();
    press(25); tick(10);
    press(8);  tick(10);
    press(25); tick(10);
    press(8);  tick(80);
    bits = 4'b1111;
    for (int k = 0; k < 4; k++) if (k < sv_q.size()) bits[k] = sv_q[k];
    n_cmp++; if (sv_cnt !== 4) begin n_err++; $display("FAIL full_sym_valid_count: got %0d expected 4", sv_cnt); end
    n_cmp++; if (bits !== 4'b0101) begin n_err++; $display("FAIL full_sym_bit_seq: got %b expected 0101 (k in bit k)", bits); end
    n_cmp++; if (le_cnt !== 1) begin n_err++; $display("FAIL full_letter_end_count: got %0d expected 1", le_cnt); end
    n_cmp++; if (le_cyc - sv_cyc !== 1) begin n_err++; $display("FAIL full_letter_end_timing: got %0d expected 1", le_cyc - sv_cyc); end
    n_cmp++; if (le_sym !== 4'b0101) begin n_err++; $display("FAIL full_letter_symbols: got %b expected 0101", le_sym); end
    n_cmp++; if (le_cnt_val !== 3'd4) begin n_err++; $display("FAIL full_letter_count: got %0d expected 4", le_cnt_val); end
    n_cmp++; if ({sym_count, symbols} !== {3'd4, 4'b0101}) begin n_err++; $display("FAIL full_hold: got %0d/%b expected 4/0101", sym_count, symbols); end
  endtask

  task automatic test_boundary();
    do_reset();
    press(20); tick(60);
    press(19); tick(60);
    n_cmp++; if (sv_cnt !== 2) begin n_err++; $display("FAIL bound_sym_valid_count: got %0d expected 2", sv_cnt); end
    n_cmp++; if (sv_q.size() < 2 || sv_q[0] !== 1'b1) begin n_err++; $display("FAIL bound_20_is_dash: got %0d expected 1", sv_q.size() > 0 ? int'(sv_q[0]) : -1); end
    n_cmp++; if (sv_q.size() < 2 || sv_q[1] !== 1'b0) begin n_err++; $display("FAIL bound_19_is_dot: got %0d expected 0", sv_q.size() > 1 ? int'(sv_q[1]) : -1); end
    n_cmp++; if (le_cnt !== 2) begin n_err++; $display("FAIL bound_letter_end_count: got %0d expected 2", le_cnt); end
    n_cmp++; if ({sym_count, symbols} !== {3'd1, 4'b0000}) begin n_err++; $display("FAIL bound_new_letter_cleared: got %0d/%b expected 1/0000", sym_count, symbols); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      key_n = (((i / 2) % 2) != 0);
      tick(1);
    end
    key_n = 1'b0;
    tick(30);
    key_n = 1'b1;
    tick(70);
    n_cmp++; if (pr_rise !== 1) begin n_err++; $display("FAIL bounce_pressed_rises: got %0d expected 1", pr_rise); end
    n_cmp++; if (sv_cnt !== 1) begin n_err++; $display("FAIL bounce_sym_valid_count: got %0d expected 1", sv_cnt); end
    n_cmp++; if (sv_q.size() < 1 || sv_q[0] !== 1'b1) begin n_err++; $display("FAIL bounce_sym_bit: got %0d expected 1", sv_q.size() > 0 ? int'(sv_q[0]) : -1); end
  endtask

  task automatic test_reset_mid_press();
    logic [10:0] outs;
    do_reset();
    key_n = 1'b0;
    tick(11);
    n_cmp++; if (pressed !== 1'b1) begin n_err++; $display("FAIL midrst_pressed_before: got %b expected 1", pressed); end
    rst_n = 1'b0;
    #1;
    outs = {pressed, sym_valid, sym_bit, sym_count, symbols, letter_end};
    n_cmp++; if (outs !== 11'd0) begin n_err++; $display("FAIL midrst_outputs: got %b expected 0", outs); end
    clear_mon();
    tick(14);
    key_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(80);
    n_cmp++; if (sv_cnt !== 0) begin n_err++; $display("FAIL midrst_no_sym_valid: got %0d expected 0", sv_cnt); end
    n_cmp++; if (le_cnt !== 0) begin n_err++; $display("FAIL midrst_no_letter_end: got %0d expected 0", le_cnt); end
    press(8);
    tick(70);
    n_cmp++; if (sv_cnt !== 1) begin n_err++; $display("FAIL midrst_next_sym_valid: got %0d expected 1", sv_cnt); end
    n_cmp++; if (sv_q.size() < 1 || sv_q[0] !== 1'b0) begin n_err++; $display("FAIL midrst_next_sym_bit: got %0d expected 0", sv_q.size() > 0 ? int'(sv_q[0]) : -1); end
    n_cmp++; if (le_cnt_val !== 3'd1) begin n_err++; $display("FAIL midrst_next_count: got %0d expected 1", le_cnt_val); end
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 1'b1;
    clear_mon();
    test_reset();
    test_single_dot();
    test_full_letter();
    test_boundary();
    test_bounce();
    test_reset_mid_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
